// File: rtl/pwm_demodulator.sv
// pwm_demodulator
// ---------------
// Measures an incoming PWM waveform and recovers its period (frame length - 1)
// and duty (high cycles), one measurement per PWM frame. The encoding matches
// the PWM modulator, so a modulator/demodulator loopback returns the same
// period/duty pair. A line that stays static for a full 2^BW-cycle frame is
// reported once as a timeout.
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   enable_i     measurement enable; low forces IDLE and clears the counters
//   pwm_i        asynchronous PWM input (synchronised internally)
//   period_o     last measured frame length - 1
//   dutyCycle_o  last measured high-phase length in cycles
//   valid_o      one-cycle pulse whenever period_o/dutyCycle_o update
//   timeout_o    high when the last update was caused by a stuck line
module pwm_demodulator #(
  parameter int BW          = 8,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          pwm_i,
  output logic [BW-1:0] period_o,
  output logic [BW-1:0] dutyCycle_o,
  output logic          valid_o,
  output logic          timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_e;

  // Counters are one bit wider than the results so that a full 2^BW-cycle
  // frame is representable; they saturate at exactly 2^BW.
  localparam logic [BW:0] CNT_MAX = {1'b1, {BW{1'b0}}};
  localparam logic [BW:0] CNT_ONE = {{BW{1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  state_e                 state_q, state_d;
  logic [BW:0]            frame_cnt_q, frame_cnt_d;
  logic [BW:0]            high_cnt_q, high_cnt_d;
  logic [BW-1:0]          period_q, period_d;
  logic [BW-1:0]          duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  logic s, rise, fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // Synchroniser and edge-detect history run regardless of enable_i, so a
  // re-enable never sees a phantom edge from stale history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      prev_q <= s;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    high_cnt_d  = high_cnt_q;
    period_d    = period_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    // Counting: a rise starts a new frame and counts itself as the first
    // cycle of both the frame and its high phase.
    if (rise) begin
      frame_cnt_d = CNT_ONE;
      high_cnt_d  = CNT_ONE;
    end else begin
      if (frame_cnt_q != CNT_MAX) begin
        frame_cnt_d = frame_cnt_q + CNT_ONE;
      end
      if (s && (high_cnt_q != CNT_MAX)) begin
        high_cnt_d = high_cnt_q + CNT_ONE;
      end
    end

    // Event priority: enable > rise > timeout > fall.
    if (!enable_i) begin
      state_d     = IDLE;
      frame_cnt_d = '0;
      high_cnt_d  = '0;
    end else if (rise) begin
      state_d = HIGH;
      // Only a rise that closes a fully observed frame is reported; the
      // frame that begins on the first rise out of IDLE/STUCK is the first
      // complete one.
      if (state_q == LOW) begin
        // frame_cnt_q <= 2^BW here; dropping the top bit before the
        // subtraction gives all-ones for a full 2^BW frame.
        period_d  = frame_cnt_q[BW-1:0] - 1'b1;
        duty_d    = high_cnt_q[BW-1:0];
        valid_d   = 1'b1;
        timeout_d = 1'b0;
      end
    end else if ((frame_cnt_q == CNT_MAX) && (state_q != STUCK)) begin
      state_d   = STUCK;
      period_d  = '1;
      duty_d    = s ? '1 : '0;
      valid_d   = 1'b1;
      timeout_d = 1'b1;
    end else if (fall && (state_q == HIGH)) begin
      state_d = LOW;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      high_cnt_q  <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      high_cnt_q  <= high_cnt_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period_o    = period_q;
  assign dutyCycle_o = duty_q;
  assign valid_o     = valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Directed testbench for pwm_demodulator (BW=8, SYNC_STAGES=2). A small
// bench-side PWM modulator drives pwm_i; every valid_o pulse is logged and
// compared against hand-derived period/duty values and report timing.
`timescale 1ns/1ps
module tb_pwm_demodulator;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          pwm_i;
  logic [BW-1:0] period_o;
  logic [BW-1:0] dutyCycle_o;
  logic          valid_o;
  logic          timeout_o;

  always #5 clk = ~clk;

  pwm_demodulator #(.BW(BW), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .pwm_i       (pwm_i),
    .period_o    (period_o),
    .dutyCycle_o (dutyCycle_o),
    .valid_o     (valid_o),
    .timeout_o   (timeout_o)
  );

  typedef struct {
    int cyc;
    int to;
    int per;
    int duty;
  } rpt_t;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc     = 0;
  rpt_t rpt_q[$];
  int   rise_q[$];

  // bench-side modulator state
  bit   mod_on    = 1'b0;
  logic mod_level = 1'b0;
  int   mod_cnt, mod_p, mod_d, nxt_p, nxt_d;
  logic last_pwm  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // One clock: sample DUT outputs at the falling edge, then drive pwm_i for
  // the next rising edge from the modulator model (or a static level).
  task automatic tick();
    rpt_t r;
    @(negedge clk);
    cyc++;
    if (valid_o === 1'b1) begin
      r.cyc  = cyc;
      r.to   = int'(timeout_o);
      r.per  = int'(period_o);
      r.duty = int'(dutyCycle_o);
      rpt_q.push_back(r);
    end
    if (mod_on) begin
      if (mod_cnt == 0) begin
        mod_p = nxt_p;
        mod_d = nxt_d;
      end
      pwm_i   = (mod_cnt < mod_d);
      mod_cnt = (mod_cnt >= mod_p) ? 0 : mod_cnt + 1;
    end else begin
      pwm_i = mod_level;
    end
    if (pwm_i && !last_pwm) rise_q.push_back(cyc);
    last_pwm = pwm_i;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    mod_on    = 1'b0;
    mod_level = 1'b0;
    rst_i     = 1'b1;
    ticks(2);
    rst_i     = 1'b0;
    rpt_q.delete();
    rise_q.delete();
  endtask

  task automatic start_stream(input int p, input int d);
    nxt_p   = p;
    nxt_d   = d;
    mod_p   = p;
    mod_d   = d;
    mod_cnt = 0;
    mod_on  = 1'b1;
    rpt_q.delete();
    rise_q.delete();
  endtask

  // A rise driven at tick r shows up as valid_o at tick r+3, and the frame
  // opened by the first usable rise is discarded: the first report follows
  // the second rise at or after tick 'from'.
  function automatic int exp_first(input int from);
    for (int i = 0; i + 1 < rise_q.size(); i++) begin
      if (rise_q[i] >= from) return rise_q[i+1] + 3;
    end
    return -2;
  endfunction

  task automatic check_stream(input string tag, input int p, input int d,
                              input int min_n, input int first_cyc);
    int bad = 0;
    int gap_bad = 0;
    int got_first;
    for (int i = 0; i < rpt_q.size(); i++) begin
      if (rpt_q[i].to != 0 || rpt_q[i].per != p || rpt_q[i].duty != d) bad++;
      if (i > 0 && (rpt_q[i].cyc - rpt_q[i-1].cyc) != p + 1) gap_bad++;
    end
    got_first = (rpt_q.size() > 0) ? rpt_q[0].cyc : -1;
    check_eq({tag, " enough_reports"}, 32'(rpt_q.size() >= min_n), 32'd1);
    check_eq({tag, " bad_values"}, bad, 0);
    check_eq({tag, " bad_spacing"}, gap_bad, 0);
    check_eq({tag, " first_report_cycle"}, got_first, first_cyc);
  endtask

  task automatic check_single(input string tag, input int to, input int per, input int duty);
    check_eq({tag, " report_count"}, rpt_q.size(), 1);
    check_eq({tag, " timeout"}, (rpt_q.size() > 0) ? rpt_q[0].to : -1, to);
    check_eq({tag, " period"}, (rpt_q.size() > 0) ? rpt_q[0].per : -1, per);
    check_eq({tag, " duty"}, (rpt_q.size() > 0) ? rpt_q[0].duty : -1, duty);
  endtask

  task automatic check_outputs(input string tag, input int per, input int duty,
                               input int v, input int to);
    check_eq({tag, " period_o"}, period_o, per);
    check_eq({tag, " dutyCycle_o"}, dutyCycle_o, duty);
    check_eq({tag, " valid_o"}, valid_o, v);
    check_eq({tag, " timeout_o"}, timeout_o, to);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int e;
    int guard;
    int n10;
    int bad;

    rst_i    = 1'b0;
    enable_i = 1'b1;
    pwm_i    = 1'b0;

    // Reset values
    do_reset();
    check_outputs("reset", 0, 0, 0, 0);

    // Basic stream P=4, D=2
    start_stream(4, 2);
    ticks(60);
    check_stream("p4d2", 4, 2, 10, exp_first(0));

    // Extremes
    do_reset();
    start_stream(255, 1);
    ticks(800);
    check_stream("p255d1", 255, 1, 2, exp_first(0));

    do_reset();
    check_outputs("reset_after_report", 0, 0, 0, 0);
    start_stream(255, 255);
    ticks(800);
    check_stream("p255d255", 255, 255, 2, exp_first(0));

    do_reset();
    start_stream(1, 1);
    ticks(40);
    check_stream("p1d1", 1, 1, 15, exp_first(0));

    // Stuck low, then stuck high followed by a resumed stream
    do_reset();
    mod_level = 1'b0;
    ticks(300);
    check_single("stuck_low", 1, 255, 0);

    do_reset();
    mod_level = 1'b1;
    ticks(300);
    check_single("stuck_high", 1, 255, 255);
    check_eq("stuck_high timeout_hold", timeout_o, 1);

    start_stream(9, 3);
    ticks(15);
    check_eq("resume no_early_report", rpt_q.size(), 0);
    check_eq("resume timeout_still_set", timeout_o, 1);
    ticks(60);
    check_stream("resume_p9d3", 9, 3, 4, exp_first(0));

    // Reset during the high phase of stream P=7, D=5
    do_reset();
    start_stream(7, 5);
    ticks(40);
    check_stream("p7d5_pre", 7, 5, 3, exp_first(0));
    guard = 0;
    while (mod_cnt != mod_d && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("p7d5 align_guard", 32'(guard < 20), 32'd1);
    rst_i = 1'b1;
    tick();
    r = cyc;
    check_outputs("midframe_reset", 0, 0, 0, 0);
    rst_i = 1'b0;
    rpt_q.delete();
    ticks(40);
    check_stream("p7d5_post", 7, 5, 3, r + 14);

    // enable_i dropped for 20 cycles during stream P=6, D=2
    do_reset();
    start_stream(6, 2);
    ticks(50);
    check_stream("p6d2_pre", 6, 2, 4, exp_first(0));
    rpt_q.delete();
    enable_i = 1'b0;
    ticks(20);
    check_eq("disabled report_count", rpt_q.size(), 0);
    check_outputs("disabled_hold", 6, 2, 0, 0);
    enable_i = 1'b1;
    e = cyc;
    ticks(50);
    check_stream("p6d2_post", 6, 2, 4, exp_first(e - 2));

    // Live change P=10, D=4 -> P=3, D=1 at a frame boundary
    do_reset();
    start_stream(10, 4);
    ticks(40);
    nxt_p = 3;
    nxt_d = 1;
    ticks(40);
    n10 = 0;
    while (n10 < rpt_q.size() && rpt_q[n10].per == 10 && rpt_q[n10].duty == 4 && rpt_q[n10].to == 0)
      n10++;
    bad = 0;
    for (int i = n10; i < rpt_q.size(); i++) begin
      if (rpt_q[i].per != 3 || rpt_q[i].duty != 1 || rpt_q[i].to != 0) bad++;
    end
    check_eq("live n_10_4_ge2", 32'(n10 >= 2), 32'd1);
    check_eq("live n_3_1_ge5", 32'(rpt_q.size() - n10 >= 5), 32'd1);
    check_eq("live bad_after_change", bad, 0);
    check_eq("live switch_gap",
             (n10 >= 1 && n10 < rpt_q.size()) ? rpt_q[n10].cyc - rpt_q[n10-1].cyc : -1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pwm_demodulator.md
Name: pwm_demodulator

Overview:
- Measures an incoming PWM waveform and recovers its period and duty-cycle values, one measurement per PWM frame.
- Values use the same encoding as the team's PwmModulator: period = frame length − 1, duty = high cycles.
- Receive-side counterpart of the modulator. Used for loopback self-test and for capturing external PWM/tone inputs into the digital core.
- Single clock domain; `pwm_i` is asynchronous and is synchronised internally.

Parameters:
- BW, 8, width of the period and duty results; the maximum measurable frame is 2^BW cycles.
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on `pwm_i` (minimum 2).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- enable_i  input  1  measurement enable; low forces IDLE.
- pwm_i  input  1  asynchronous PWM input.
- period_o  output  BW  last measured frame length − 1.
- dutyCycle_o  output  BW  last measured high-phase length in cycles.
- valid_o  output  1  one-cycle pulse when `period_o`/`dutyCycle_o` update.
- timeout_o  output  1  set when the last update was caused by a stuck line.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - Synchroniser flops, `prev` = 0; state = IDLE.
  - frameCnt = 0, highCnt = 0.
  - All outputs = 0.
  - Reset mid-frame discards the partial frame.
- Edge detection:
  - `s` = last synchroniser stage; `prev` <= `s` every cycle.
  - rise = s & ~prev; fall = ~s & prev.
- Counters:
  - frameCnt and highCnt are BW+1 bits wide and saturate at 2^BW.
  - On a rise cycle: frameCnt <= 1, highCnt <= 1.
  - Otherwise: frameCnt increments; highCnt increments only while s=1.
- States:
  - IDLE: wait for first rise, then go to HIGH. The partial first frame is never reported.
  - HIGH: on fall, go to LOW.
  - LOW: on rise, report the frame and go to HIGH.
  - STUCK: line static too long; on rise, go to HIGH.
- Report (LOW + rise): registered on the same edge.
  - period_o <= frameCnt − 1 (pre-update value of frameCnt).
  - dutyCycle_o <= highCnt.
  - valid_o <= 1; timeout_o <= 0.
  - Guaranteed ranges: frameCnt ≤ 2^BW and highCnt < frameCnt, so both results fit in BW bits.
- Latency: if pwm_i is first sampled high at edge k, valid_o is high after edge k+SYNC_STAGES, for exactly one cycle.
- Timeout:
  - Trigger: in IDLE, HIGH or LOW, frameCnt == 2^BW and no rise this cycle.
  - Next state = STUCK; valid_o pulses once; timeout_o <= 1; period_o <= all-ones.
  - dutyCycle_o <= all-ones if s=1, else 0.
  - No further pulses while in STUCK.
  - timeout_o holds until the next normal report or reset.
- enable_i = 0:
  - State = IDLE; counters cleared; valid_o = 0.
  - period_o, dutyCycle_o and timeout_o hold their values.
  - The synchroniser keeps running.
- Priority when events coincide: rst_i > enable_i > rise > timeout > fall.
- Round-trip requirement: a modulator with period P and duty D, where 0 < D ≤ P, must demodulate to exactly P and D.
  - D = 0 reads as stuck low.
  - D > P reads as stuck high.

Test Plan:
- Modulator stream P=4, D=2 after reset (BW=8, SYNC=2):
  - First frame discarded.
  - Then valid_o pulses every 5 cycles with period_o=4, dutyCycle_o=2, timeout_o=0.
- Extremes P=255, D=1 and P=255, D=255 -> period_o=255 with dutyCycle_o=1 and 255 respectively. Also P=1, D=1 -> period_o=1, dutyCycle_o=1, pulses every 2 cycles.
- Stuck line:
  - pwm_i held 0 for 300 cycles after reset -> exactly one valid pulse, timeout_o=1, period_o=255, dutyCycle_o=0.
  - Held 1 instead -> dutyCycle_o=255.
  - A resumed stream P=9, D=3 -> timeout_o=0 at the first report, with period_o=9, dutyCycle_o=3.
- rst_i asserted for 1 cycle mid-HIGH phase with stream P=7, D=5:
  - All outputs 0 on the next edge.
  - No report for the interrupted frame or the first frame after reset.
  - Next report is 7/5.
- enable_i dropped for 20 cycles during stream P=6, D=2:
  - valid_o stays 0 and outputs hold 6/2.
  - After re-enable, the first frame is discarded, then 6/2 reports resume.
- Live change from P=10, D=4 to P=3, D=1 at a frame boundary -> reports 10/4 followed immediately by 3/1, with no spurious or mixed values.
